stream_read_source: RTL

STREAM_READ_SOURCE -- requirements
Module: stream_read_source

---
 rtl/stream_src_pkg.sv | 15 +
 rtl/sync_fifo.sv | 78 +++++++
 rtl/stream_read_source.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/stream_src_pkg.sv
// Shared definitions for the stream read source: FSM state encoding and
// the magic value placed in the upper half of each session header word.
package stream_src_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_EOF   = 3'd4
    } stream_state_e;

    localparam logic [15:0] HEADER_MAGIC = 16'hA5A5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an inferred RAM, standard (registered) read timing,
// an exact occupancy count and a synchronous flush.
// Full is judged on the current level, so a write while full is dropped even
// if a read frees a slot on the same edge. A read while empty is ignored.
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = LEVEL_ONE[DEPTH_LOG2-1:0];

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full   = (level == LEVEL_FULL);
    assign empty  = (level == '0);
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and level; they wrap naturally at the pointer width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Read data register: loads on an accepted read and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_acc) begin
            rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/stream_read_source.sv
// Xillybus-style 32-bit read source: captures sample words into a FIFO
// while the host has the device file open and capture is enabled, then
// drains and signals end of stream.
// Optional feature: define STREAM_HEADER_EN to prefix every capture session
// with a header word {HEADER_MAGIC, seq}.
// Host handshake: a read is accepted on an edge where rden=1 and empty=0;
// the word appears on user_r_read_32_data after that edge and then holds.
module stream_read_source
    import stream_src_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int OVF_W      = 16
) (
    input  logic                  bus_clk,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    input  logic [31:0]           sample_data,
    input  logic                  capture_en,
    input  logic                  user_r_read_32_open,
    input  logic                  user_r_read_32_rden,
    output logic [31:0]           user_r_read_32_data,
    output logic                  user_r_read_32_empty,
    output logic                  user_r_read_32_eof,
    output logic [OVF_W-1:0]      overflow_count,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  running,
    output stream_state_e         state_dbg
);

    stream_state_e state;
    stream_state_e state_nxt;
    logic          started;
    logic          flush;
    logic          enter_run;
    logic          fifo_full;
    logic          fifo_empty;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic          rd_en;
    logic          drop;

    // Transitions are held off for the first edge after reset release.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; closing the file from any active state flushes.
    // DRAIN finishes once the FIFO is empty: any read accepted earlier has
    // already been loaded into the data register by then.
    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        if (started) begin
            if (state != ST_IDLE && !user_r_read_32_open) begin
                state_nxt = ST_IDLE;
                flush     = 1'b1;
            end else begin
                case (state)
                    ST_IDLE:  if (user_r_read_32_open) state_nxt = ST_ARMED;
                    ST_ARMED: if (capture_en)          state_nxt = ST_RUN;
                    ST_RUN:   if (!capture_en)         state_nxt = ST_DRAIN;
                    ST_DRAIN: if (fifo_empty)          state_nxt = ST_EOF;
                    ST_EOF:   state_nxt = ST_EOF;
                    default:  state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    assign enter_run = (state == ST_ARMED) && (state_nxt == ST_RUN);

`ifdef STREAM_HEADER_EN
    logic        hdr_pending;
    logic        hdr_wr;
    logic [15:0] seq;

    assign hdr_wr  = (state == ST_RUN) && hdr_pending;
    assign wr_en   = (state == ST_RUN) && (hdr_wr || sample_valid);
    assign wr_data = hdr_wr ? {HEADER_MAGIC, seq} : sample_data;
    assign drop    = (state == ST_RUN) && sample_valid && (hdr_wr || fifo_full);

    // Header request is raised on RUN entry and served in the first RUN cycle.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_pending <= 1'b0;
            seq         <= 16'd0;
        end else if (enter_run) begin
            hdr_pending <= 1'b1;
        end else if (hdr_wr) begin
            hdr_pending <= 1'b0;
            seq         <= seq + 16'd1;
        end
    end
`else
    assign wr_en   = (state == ST_RUN) && sample_valid;
    assign wr_data = sample_data;
    assign drop    = (state == ST_RUN) && sample_valid && fifo_full;
`endif

    // Overflow counter: cleared on RUN entry, saturates at all-ones.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_count <= '0;
        end else if (enter_run) begin
            overflow_count <= '0;
        end else if (drop && (overflow_count != '1)) begin
            overflow_count <= overflow_count + OVF_W'(1);
        end
    end

    assign user_r_read_32_empty = fifo_empty || (state == ST_IDLE) || (state == ST_EOF);
    assign user_r_read_32_eof   = (state == ST_EOF);
    assign running              = (state == ST_RUN);
    assign state_dbg            = state;
    assign rd_en                = user_r_read_32_rden && !user_r_read_32_empty;

    sync_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (bus_clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (user_r_read_32_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
